div_seq_frac: RTL and testbench
===============================

// Module: div_seq_frac
// PURPOSE
//  Multi-cycle restoring unsigned divider with valid/ready handshakes. Computes q = n/d, r = n%d and,
//  when requested, a scaled fraction floor(r*FRAC_SCALE/d). Fixed-point results come from one block
//  instead of chained combinational stages. Sits between the pixel/coordinate arithmetic and the
//  display datapath; trades latency for a small critical path (BPC subtract/compare steps per cycle).
// PARAMETERS
//  WIDTH       10    dividend/divisor/quotient/remainder width
//  BPC         1     quotient bits resolved per clock; must divide WIDTH and FRAC_W
//  FRAC_SCALE  1000  fraction scale factor (decimal digits: 10, 100, 1000)
//  FRAC_W      10    fraction width; FRAC_SCALE <= 2**FRAC_W required (elaboration-time check)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous reset, active low
//  in_valid   in   1         operands present
//  in_ready   out  1         block idle, operands accepted on in_valid&&in_ready
//  in_n       in   WIDTH     dividend
//  in_d       in   WIDTH     divisor
//  in_frac    in   1         1 = also compute fraction
//  out_valid  out  1         result held until out_ready
//  out_ready  in   1         consumer takes result
//  out_q      out  WIDTH     quotient
//  out_r      out  WIDTH     integer remainder
//  out_frac   out  FRAC_W    floor(out_r*FRAC_SCALE/d); 0 when in_frac=0
//  out_dbz    out  1         divide-by-zero flag
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE; out_valid, out_q, out_r, out_frac, out_dbz = 0; in_ready=1.
//  in_ready = (state==IDLE). No accept while busy or while a result waits.
//  FSM: IDLE -accept-> INT (d!=0) or DONE (d==0); INT -K edges-> FRAC (frac) or DONE; FRAC -KF edges-> DONE;
//    DONE -out_ready-> IDLE. K=WIDTH/BPC, KF=FRAC_W/BPC.
//  Accept edge latches n, d, frac flag; clears rem (WIDTH+FRAC_W+1 bits) and quotient; cnt=0.
//  INT step, repeated BPC times per cycle: rem={rem,next MSB of n}; if rem>=d then rem-=d, qbit=1.
//  Last INT edge stores out_r=rem[WIDTH-1:0]. If frac: load dividend = rem*FRAC_SCALE (WIDTH+FRAC_W bits).
//    FRAC reuses the same step over FRAC_W bits to produce out_frac. r<d guarantees no overflow.
//  out_valid is high from edge K (int only) or K+KF (frac) after the accept edge. Outputs stable while
//    out_valid&&!out_ready. Handoff edge: out_valid->0 and in_ready->1 next cycle (1 idle bubble).
//  d==0: DONE on the edge after accept; out_q=all ones, out_r=n, out_frac=0, out_dbz=1. No X outputs.
//  out_dbz, out_q, out_r and out_frac update only when entering DONE; they keep their values in IDLE.
//  Reset mid-operation aborts immediately; the in-flight result is lost and no out_valid is emitted.
//  in_* changes while not accepted are ignored; out_ready while !out_valid is ignored.
// STRUCTURE
//  div_pkg: state enum (S_IDLE, S_INT, S_FRAC, S_DONE), clog2 function, parameter legality checks.
//  div_step (sub-module, combinational, param W): in rem, d, bit -> rem_next, qbit.
//    Instantiated BPC times in a generate chain; shared by INT and FRAC phases.
//  Top: FSM, phase counter (clog2(max(K,KF))+1 bits), operand/quotient shift registers, output registers.
// TESTING
//  1 Defaults, n=1000 d=7 frac=1 -> q=142 r=6 frac=857 dbz=0; out_valid exactly 20 edges after accept.
//  2 n=5 d=9 frac=0 -> q=0 r=5 frac=0; out_valid 10 edges after accept. n=1023 d=1 -> q=1023 r=0.
//  3 d=0, n=77 -> q=1023 r=77 frac=0 dbz=1; out_valid 1 edge after accept.
//  4 Back-pressure: out_ready low for 15 cycles -> outputs constant, in_ready=0; accept resumes after handoff.
//  5 rst_n pulsed low mid-INT (cycle 4) -> out_valid=0, in_ready=1 at once; next op n=100 d=3 -> q=33 r=1.
//  6 BPC=2: n=1000 d=7 frac=1 -> same results; out_valid 10 edges after accept. Random sweep vs golden model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and elaboration helpers for the sequential fractional divider.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INT  = 2'd1,
        S_FRAC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 10;
    localparam int DEF_BPC        = 1;
    localparam int DEF_FRAC_SCALE = 1000;
    localparam int DEF_FRAC_W     = 10;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Parameter legality: BPC must divide both phase widths, and the scaled
    // remainder must fit the product register (FRAC_SCALE <= 2**FRAC_W).
    function automatic bit params_ok(input int width, input int bpc,
                                     input int frac_scale, input int frac_w);
        return (width > 0) && (bpc > 0) && (frac_w > 0) && (frac_w < 31) &&
               (width % bpc == 0) && (frac_w % bpc == 0) &&
               (frac_scale > 0) && (frac_scale <= (1 << frac_w));
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, report the resulting quotient bit.
module div_step #(
    parameter int W  = 21,
    parameter int DW = 10
) (
    input  logic [W-1:0]  rem,
    input  logic [DW-1:0] d,
    input  logic          bit_in,
    output logic [W-1:0]  rem_next,
    output logic          qbit
);

    logic [W:0] shifted;
    logic [W:0] d_ext;

    // Compare/subtract on a one-bit-wider value so no remainder bit is dropped.
    always_comb begin
        shifted  = {rem, bit_in};
        d_ext    = (W+1)'(d);
        qbit     = (shifted >= d_ext);
        rem_next = qbit ? W'(shifted - d_ext) : shifted[W-1:0];
    end

endmodule

// File: rtl/div_seq_frac.sv
// Multi-cycle restoring unsigned divider with optional scaled fraction.
// Handshake: an operand is taken on the rising edge where in_valid && in_ready
// (in_ready only in IDLE); a result is presented with out_valid held high and
// outputs frozen until the edge where out_valid && out_ready, after which the
// block spends one cycle back in IDLE before it can accept again.
module div_seq_frac
    import div_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BPC        = DEF_BPC,
    parameter int FRAC_SCALE = DEF_FRAC_SCALE,
    parameter int FRAC_W     = DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_n,
    input  logic [WIDTH-1:0]  in_d,
    input  logic              in_frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_q,
    output logic [WIDTH-1:0]  out_r,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_dbz
);

    localparam int K    = WIDTH / BPC;
    localparam int KF   = FRAC_W / BPC;
    localparam int KMAX = (K > KF) ? K : KF;
    localparam int CW   = clog2(KMAX) + 1;
    localparam int RW   = WIDTH + FRAC_W + 1;
    localparam int SW   = (WIDTH > FRAC_W) ? WIDTH : FRAC_W;
    localparam int PW   = WIDTH + FRAC_W;

    if (!params_ok(WIDTH, BPC, FRAC_SCALE, FRAC_W)) begin : g_param_err
        $error("div_seq_frac: illegal WIDTH/BPC/FRAC_SCALE/FRAC_W combination");
    end

    state_t state;
    state_t state_next;

    logic [SW-1:0]    n_sh;     // dividend bits still to be shifted in, MSB first
    logic [WIDTH-1:0] d_reg;
    logic             frac_reg;
    logic [RW-1:0]    rem;
    logic [SW-1:0]    q_sh;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_hold;   // integer results parked during the fraction phase
    logic [WIDTH-1:0] r_hold;

    logic             accept;
    logic             last_int;
    logic             last_frac;
    logic [BPC-1:0]   qbits;
    logic [RW-1:0]    rem_out;
    logic [SW-1:0]    q_next;
    logic [PW-1:0]    prod;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign last_int  = (cnt == CW'(K - 1));
    assign last_frac = (cnt == CW'(KF - 1));

    // BPC chained steps per cycle; stage 0 consumes the current MSB of n_sh.
    for (genvar i = 0; i < BPC; i++) begin : g_step
        logic [RW-1:0] rem_i;
        logic [RW-1:0] rem_o;
        logic          qb;
        if (i == 0) begin : g_first
            assign rem_i = rem;
        end else begin : g_next
            assign rem_i = g_step[i-1].rem_o;
        end
        div_step #(.W(RW), .DW(WIDTH)) u_step (
            .rem      (rem_i),
            .d        (d_reg),
            .bit_in   (n_sh[SW-1-i]),
            .rem_next (rem_o),
            .qbit     (qb)
        );
        assign qbits[BPC-1-i] = qb;
    end

    assign rem_out = g_step[BPC-1].rem_o;
    assign q_next  = (q_sh << BPC) | SW'(qbits);
    // Integer remainder scaled for the fraction phase; r < d keeps the
    // upper WIDTH bits below d, so the fraction quotient fits FRAC_W bits.
    assign prod    = PW'(rem_out[WIDTH-1:0]) * PW'(FRAC_SCALE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = (in_d == '0) ? S_DONE : S_INT;
            S_INT:  if (last_int) state_next = frac_reg ? S_FRAC : S_DONE;
            S_FRAC: if (last_frac) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-cycle division steps, result registers
    // loaded only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_sh     <= '0;
            d_reg    <= '0;
            frac_reg <= 1'b0;
            rem      <= '0;
            q_sh     <= '0;
            cnt      <= '0;
            q_hold   <= '0;
            r_hold   <= '0;
            out_q    <= '0;
            out_r    <= '0;
            out_frac <= '0;
            out_dbz  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        n_sh     <= SW'(in_n) << (SW - WIDTH);
                        d_reg    <= in_d;
                        frac_reg <= in_frac;
                        rem      <= '0;
                        q_sh     <= '0;
                        cnt      <= '0;
                        if (in_d == '0) begin
                            out_q    <= '1;
                            out_r    <= in_n;
                            out_frac <= '0;
                            out_dbz  <= 1'b1;
                        end
                    end
                end
                S_INT: begin
                    rem  <= rem_out;
                    n_sh <= n_sh << BPC;
                    q_sh <= q_next;
                    cnt  <= cnt + CW'(1);
                    if (last_int) begin
                        cnt <= '0;
                        if (frac_reg) begin
                            q_hold <= q_next[WIDTH-1:0];
                            r_hold <= rem_out[WIDTH-1:0];
                            rem    <= RW'(prod >> FRAC_W);
                            n_sh   <= SW'(prod[FRAC_W-1:0]) << (SW - FRAC_W);
                            q_sh   <= '0;
                        end else begin
                            out_q    <= q_next[WIDTH-1:0];
                            out_r    <= rem_out[WIDTH-1:0];
                            out_frac <= '0;
                            out_dbz  <= 1'b0;
                        end
                    end
                end
                S_FRAC: begin
                    rem  <= rem_out;
                    n_sh <= n_sh << BPC;
                    q_sh <= q_next;
                    cnt  <= cnt + CW'(1);
                    if (last_frac) begin
                        cnt      <= '0;
                        out_q    <= q_hold;
                        out_r    <= r_hold;
                        out_frac <= q_next[FRAC_W-1:0];
                        out_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_frac.sv
// Bench: two instances (BPC=1 and BPC=2) share the operand and consumer
// signals; every result is compared with plain integer arithmetic.
module tb_div_seq_frac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_frac;
    logic       out_ready;
    logic [9:0] in_n;
    logic [9:0] in_d;

    logic       ready1, valid1, dbz1;
    logic [9:0] q1, r1, f1;
    logic       ready2, valid2, dbz2;
    logic [9:0] q2, r2, f2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq_frac #(.WIDTH(10), .BPC(1), .FRAC_SCALE(1000), .FRAC_W(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready1),
        .in_n(in_n), .in_d(in_d), .in_frac(in_frac), .out_valid(valid1),
        .out_ready(out_ready), .out_q(q1), .out_r(r1), .out_frac(f1), .out_dbz(dbz1)
    );

    div_seq_frac #(.WIDTH(10), .BPC(2), .FRAC_SCALE(1000), .FRAC_W(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready2),
        .in_n(in_n), .in_d(in_d), .in_frac(in_frac), .out_valid(valid2),
        .out_ready(out_ready), .out_q(q2), .out_r(r2), .out_frac(f2), .out_dbz(dbz2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, measure latency of both instances, compare
    // results, hold back-pressure for 'hold' cycles, then hand off.
    task automatic run_op(input int n, input int d, input bit fr, input int hold);
        int         lat1, lat2, waitc, exp_lat1, exp_lat2;
        logic [9:0] e_q, e_r, e_f;
        logic       e_dbz;
        e_dbz = (d == 0);
        e_q   = (d == 0) ? 10'd1023 : 10'(n / d);
        e_r   = (d == 0) ? 10'(n) : 10'(n % d);
        e_f   = (d == 0 || !fr) ? 10'd0 : 10'((int'(e_r) * 1000) / d);
        exp_lat1 = (d == 0) ? 1 : (fr ? 20 : 10);
        exp_lat2 = (d == 0) ? 1 : (fr ? 10 : 5);

        waitc = 0;
        while (!(ready1 && ready2) && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("in_ready_before_accept", {ready1, ready2}, 2'b11);

        in_n = 10'(n); in_d = 10'(d); in_frac = fr; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_n = 10'($urandom); in_d = 10'($urandom); in_frac = 1'($urandom);

        lat1 = -1; lat2 = -1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            if (valid1 && lat1 < 0) lat1 = e;
            if (valid2 && lat2 < 0) lat2 = e;
            if (lat1 >= 0 && lat2 >= 0) break;
        end
        check("latency_bpc1", lat1, exp_lat1);
        check("latency_bpc2", lat2, exp_lat2);
        check("in_ready_low_while_done", {ready1, ready2}, 2'b00);
        check("result_bpc1", {dbz1, q1, r1, f1}, {e_dbz, e_q, e_r, e_f});
        check("result_bpc2", {dbz2, q2, r2, f2}, {e_dbz, e_q, e_r, e_f});

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_n = 10'($urandom); in_d = 10'($urandom); in_frac = 1'($urandom);
            @(negedge clk);
            check("hold_bpc1", {valid1, ready1, dbz1, q1, r1, f1}, {2'b10, e_dbz, e_q, e_r, e_f});
            check("hold_bpc2", {valid2, ready2, dbz2, q2, r2, f2}, {2'b10, e_dbz, e_q, e_r, e_f});
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_valid_ready", {valid1, ready1, valid2, ready2}, 4'b0101);
        check("retain_in_idle", {dbz1, q1, r1, f1, dbz2, q2, r2, f2},
              {e_dbz, e_q, e_r, e_f, e_dbz, e_q, e_r, e_f});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, d, hold;
        bit fr;
        rst_n = 1'b0; in_valid = 1'b0; in_frac = 1'b0; out_ready = 1'b0;
        in_n = '0; in_d = '0;
        repeat (3) @(negedge clk);
        check("reset_bpc1", {valid1, ready1, dbz1, q1, r1, f1}, {2'b01, 31'd0});
        check("reset_bpc2", {valid2, ready2, dbz2, q2, r2, f2}, {2'b01, 31'd0});
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1000, 7, 1'b1, 0);
        run_op(5, 9, 1'b0, 0);
        run_op(1023, 1, 1'b0, 1);
        run_op(77, 0, 1'b1, 0);
        run_op(1023, 1023, 1'b1, 0);
        run_op(1022, 1023, 1'b1, 2);
        run_op(0, 5, 1'b1, 0);
        run_op(1000, 7, 1'b1, 15);

        // Abort mid-operation: after four INT cycles, reset takes effect at once.
        in_n = 10'd500; in_d = 10'd3; in_frac = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", {ready1, valid1}, 2'b00);
        rst_n = 1'b0;
        #1;
        check("abort_bpc1", {valid1, ready1, q1, r1}, {2'b01, 20'd0});
        check("abort_bpc2", {valid2, ready2, q2, r2}, {2'b01, 20'd0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_valid_after_abort", {valid1, valid2}, 2'b00);
        run_op(100, 3, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 1023);
            if ($urandom_range(0, 15) == 0) d = 0;
            else if ($urandom_range(0, 3) == 0) d = $urandom_range(1, 15);
            else d = $urandom_range(1, 1023);
            fr   = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            run_op(n, d, fr, hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
